link_test_ctrl: RTL

Sequencer for the serial-link receive checker. On a software START it clears the checker, requests alignment, waits for lock, issues INIT, and counts the WORDS test words the checker compares. It then lets the checker's error counter settle, latches the result and reports pass, bit-error or link-failure. Alignment timeouts and loss of lock are retried up to MAX_RETRY times. It sits between the register block (START/ABORT/status) and the aligner plus checker pair.

---
 rtl/link_test_pkg.sv | 23 ++
 rtl/lt_timer.sv | 30 +++
 rtl/link_test_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/link_test_pkg.sv
// Shared types and constants for the serial-link receive test sequencer.
package link_test_pkg;

  localparam int TMR_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ALIGN,
    S_INIT,
    S_RUN,
    S_DRAIN,
    S_EVAL
  } state_e;

  typedef enum logic [1:0] {
    ST_NONE     = 2'd0,
    ST_PASS     = 2'd1,
    ST_BITERR   = 2'd2,
    ST_LINKFAIL = 2'd3
  } status_e;

endpackage

// File: rtl/lt_timer.sv
// Loadable down-counter shared by the ALIGN lock timeout and the RUN word-gap timeout.
module lt_timer
  import link_test_pkg::*;
(
  input  logic             RSTX,
  input  logic             CLK,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  output logic             o_expired
);

  logic [TMR_W-1:0] r_cnt;

  // Parks at zero, so expiry stays asserted until the next load.
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/link_test_ctrl.sv
// Sequencer for the receive checker: clear, align, init, count words, drain, evaluate, with retry.
//   state | meaning
//   IDLE  | waiting for START
//   CLEAR | one-cycle CLR to checker, arm align timeout
//   ALIGN | ALIGN_REQ high until lock or timeout
//   INIT  | one-cycle INIT, arm word counter and gap timer
//   RUN   | count valid words; loss of lock or gap timeout retries
//   DRAIN | let the checker error count settle
//   EVAL  | latch result, pulse DONE
module link_test_ctrl
  import link_test_pkg::*;
#(
  parameter int WORDS     = 1024,
  parameter int ALIGN_TO  = 65535,
  parameter int MAX_RETRY = 3,
  parameter int DRAIN     = 4
) (
  input  logic       RSTX,
  input  logic       CLK,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_aligned,
  input  logic       i_dipush,
  input  logic [7:0] i_err_cnt,
  output logic       o_align_req,
  output logic       o_clr,
  output logic       o_init,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_status,
  output logic [7:0] o_result_err,
  output logic [3:0] o_retry_cnt
);

  localparam int                WCNT_W      = $clog2(WORDS) + 1;
  localparam int                DCNT_W      = $clog2(DRAIN) + 1;
  localparam logic [WCNT_W-1:0] WORDS_V     = WCNT_W'(WORDS);
  localparam logic [TMR_W-1:0]  ALIGN_TO_V  = TMR_W'(ALIGN_TO);
  localparam logic [DCNT_W-1:0] DRAIN_LAST  = DCNT_W'(DRAIN - 1);
  localparam logic [3:0]        MAX_RETRY_V = 4'(MAX_RETRY);

  state_e            r_state;
  state_e            w_next;
  logic [WCNT_W-1:0] r_words;
  logic [DCNT_W-1:0] r_drain;
  logic [3:0]        r_retry;
  status_e           r_status;
  logic [7:0]        r_result_err;
  logic              r_done;
  logic              r_abort_clr;

  logic w_word;
  logic w_last_word;
  logic w_abort;
  logic w_expired;
  logic w_retry_evt;
  logic w_can_retry;
  logic w_tmr_load;
  logic w_tmr_clr;

  assign w_word      = i_dipush & i_aligned;
  assign w_last_word = (r_state == S_RUN) && w_word && (r_words == WCNT_W'(1));
  assign w_abort     = i_abort && (r_state != S_IDLE);
  assign w_can_retry = (r_retry < MAX_RETRY_V);

  // Completion is checked before loss of lock, so the final word always wins.
  assign w_retry_evt = ((r_state == S_ALIGN) && !i_aligned && w_expired) ||
                       ((r_state == S_RUN) && !w_last_word &&
                        (!i_aligned || (w_expired && !w_word)));

  assign w_tmr_load = (r_state == S_CLEAR) || (r_state == S_INIT) ||
                      ((r_state == S_RUN) && w_word);
  assign w_tmr_clr  = (r_state == S_IDLE);

  lt_timer u_timer (
    .RSTX       (RSTX),
    .CLK        (CLK),
    .i_clr      (w_tmr_clr),
    .i_load     (w_tmr_load),
    .i_load_val (ALIGN_TO_V),
    .o_expired  (w_expired)
  );

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start) w_next = S_CLEAR;
        S_CLEAR: w_next = S_ALIGN;
        S_ALIGN: begin
          if (i_aligned)        w_next = S_INIT;
          else if (w_retry_evt) w_next = w_can_retry ? S_CLEAR : S_IDLE;
        end
        S_INIT:  w_next = S_RUN;
        S_RUN: begin
          if (w_last_word)      w_next = S_DRAIN;
          else if (w_retry_evt) w_next = w_can_retry ? S_CLEAR : S_IDLE;
        end
        S_DRAIN: if (r_drain == '0) w_next = S_EVAL;
        S_EVAL:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_align_req = (r_state == S_ALIGN);
    o_clr       = (r_state == S_CLEAR) || r_abort_clr;
    o_init      = (r_state == S_INIT);
    o_busy      = (r_state != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      r_words <= '0;
      r_drain <= '0;
    end else begin
      if (r_state == S_INIT) begin
        r_words <= WORDS_V;
      end else if ((r_state == S_RUN) && w_word) begin
        r_words <= r_words - 1'b1;
      end
      if (w_last_word) begin
        r_drain <= DRAIN_LAST;
      end else if ((r_state == S_DRAIN) && (r_drain != '0)) begin
        r_drain <= r_drain - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      r_retry      <= '0;
      r_status     <= ST_NONE;
      r_result_err <= '0;
      r_done       <= 1'b0;
      r_abort_clr  <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_abort_clr <= w_abort;
      if (w_abort) begin
        r_status <= ST_NONE;
      end else if ((r_state == S_IDLE) && i_start) begin
        r_retry  <= '0;
        r_status <= ST_NONE;
      end else if (w_retry_evt) begin
        if (w_can_retry) begin
          if (r_retry != 4'hF) r_retry <= r_retry + 4'd1;
        end else begin
          r_status     <= ST_LINKFAIL;
          r_result_err <= 8'hFF;
          r_done       <= 1'b1;
        end
      end else if ((r_state == S_DRAIN) && (w_next == S_EVAL)) begin
        // Latched on entry so STATUS, RESULT_ERR and DONE are all valid during EVAL.
        r_result_err <= i_err_cnt;
        r_status     <= (i_err_cnt == 8'd0) ? ST_PASS : ST_BITERR;
        r_done       <= 1'b1;
      end
    end
  end

  assign o_done       = r_done;
  assign o_status     = r_status;
  assign o_result_err = r_result_err;
  assign o_retry_cnt  = r_retry;

endmodule
